vdp_cpu_port: RTL
=================

Name: vdp_cpu_port

Overview:
- CPU-side write/read port of the VDP. This is the end that fills and reads back the name, pattern and colour tables, and loads the control registers, that the display pipeline consumes.
- Implements the TMS9918-style two-port protocol:
  - mode 0 is the data port.
  - mode 1 is the control port, with a two-byte address/register sequence.
- Provides address auto-increment and a one-byte read-ahead buffer.
- Drives the write/read side of a dual-port VRAM whose other port is read by the display logic.

Parameters:
- ADDR_W, 14, VRAM address width; address wraps modulo 2^ADDR_W.
- NREG, 8, number of VDP control registers; register index is din[2:0].

Ports:
- pxclk  in  1  system clock (65 MHz); all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_wr  in  1  one-cycle CPU write strobe.
- cpu_rd  in  1  one-cycle CPU read strobe.
- cpu_mode  in  1  0 = data port, 1 = control port.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  registered CPU read data.
- cpu_busy  out  1  high while a VRAM prefetch is in progress; strobes are ignored while high.
- status_in  in  8  VDP status byte.
- status_clr  out  1  one-cycle pulse when status is read.
- vram_addr  out  ADDR_W  VRAM address for a write or read.
- vram_we  out  1  VRAM write enable, one cycle.
- vram_wdata  out  8  VRAM write data.
- vram_re  out  1  VRAM read enable, one cycle.
- vram_rdata  in  8  VRAM read data, valid 1 cycle after vram_re.
- regs  out  8*NREG  register file, flattened; reg n occupies bits [8n+7:8n].

Behaviour:
- Reset values:
  - addr = 0, first-byte latch = 0, latch_full = 0, readbuf = 0.
  - regs = 0, cpu_dout = 0.
  - cpu_busy, status_clr, vram_we and vram_re = 0.
  - FSM returns to IDLE, aborting any prefetch in flight; vram_rdata arriving after reset is discarded.
- Strobe arbitration:
  - If cpu_wr and cpu_rd are both high in the same cycle, cpu_wr wins and cpu_rd is dropped.
  - Strobes arriving while cpu_busy = 1 are dropped and change no state.
- Control write with latch_full = 0:
  - latch <= din, latch_full <= 1. No other effect.
- Control write with latch_full = 1 (always sets latch_full <= 0):
  - din[7] = 1: register write. regs[din[2:0]] <= latch, visible on the cycle after the strobe. din[6:3] are ignored.
  - din[7:6] = 01: write setup. addr <= {din[5:0], latch}[ADDR_W-1:0]. No VRAM access.
  - din[7:6] = 00: read setup. addr is set the same way, then a prefetch starts.
- Data write:
  - In the cycle after the strobe: vram_we = 1, vram_addr = addr, vram_wdata = din.
  - readbuf <= din; addr <= addr + 1; latch_full <= 0.
- Data read:
  - cpu_dout <= readbuf on the cycle after the strobe.
  - latch_full <= 0, then a prefetch starts.
- Control read:
  - cpu_dout <= status_in on the cycle after the strobe.
  - status_clr pulses for 1 cycle; latch_full <= 0.
- Prefetch FSM, states IDLE -> RD_ISSUE -> RD_WAIT -> IDLE:
  - RD_ISSUE (cycle after the triggering strobe): vram_re = 1, vram_addr = addr, cpu_busy = 1.
  - RD_WAIT: readbuf <= vram_rdata, addr <= addr + 1, cpu_busy = 1.
  - Back in IDLE, cpu_busy = 0. Total busy time is 2 cycles.
- Address arithmetic:
  - All increments are modulo 2^ADDR_W: 0x3FFF + 1 = 0x0000.
  - Unused high bits of din[5:0] beyond ADDR_W are discarded.
- vram_we and vram_re are never high in the same cycle.

Test Plan:
- Reset, then check outputs: regs = 0, cpu_dout = 0, cpu_busy = 0, no vram_we or vram_re.
- Register write: ctrl 0xA5 then ctrl 0x87 -> regs[7] = 0xA5 one cycle later; latch_full = 0; no VRAM activity.
- Write setup plus bursts:
  - ctrl 0x00 then ctrl 0x78 sets addr = 0x3800.
  - Data writes 0x11, 0x22, 0x33 -> vram_we pulses at 0x3800, 0x3801, 0x3802 with those bytes.
- Wrap-around and read-ahead:
  - Write setup to 0x3FFF; data write 0x5A -> write lands at 0x3FFF.
  - Read setup to 0x3FFF, with VRAM holding 0x5A there and 0x9C at 0x0000.
  - busy for 2 cycles; then data read -> cpu_dout = 0x5A; prefetch issued at 0x0000; readbuf = 0x9C; addr = 0x0001.
- Latch reset and status:
  - ctrl 0x34, then ctrl read with status_in = 0x80 -> cpu_dout = 0x80 and status_clr pulses.
  - Next ctrl 0x12 is treated as a first byte, so no register or address change.
- Busy, collision and mid-operation reset:
  - Data write issued during a prefetch -> dropped, no vram_we.
  - cpu_wr and cpu_rd together -> only the write occurs.
  - reset asserted in RD_WAIT -> readbuf = 0, addr = 0, busy = 0 on the next cycle.

Source files
------------

// File: rtl/vdp_cpu_port.sv
// CPU side of the VDP: TMS9918-style data/control ports, control-register file,
// address auto-increment and a one-byte VRAM read-ahead buffer.
module vdp_cpu_port #(
  parameter int ADDR_W = 14,
  parameter int NREG   = 8
) (
  input  logic                pxclk,
  input  logic                reset,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  input  logic                cpu_mode,
  input  logic [7:0]          cpu_din,
  output logic [7:0]          cpu_dout,
  output logic                cpu_busy,
  input  logic [7:0]          status_in,
  output logic                status_clr,
  output logic [ADDR_W-1:0]   vram_addr,
  output logic                vram_we,
  output logic [7:0]          vram_wdata,
  output logic                vram_re,
  input  logic [7:0]          vram_rdata,
  output logic [8*NREG-1:0]   regs
);

  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [7:0]             latch_q, latch_d;
  logic                   lf_q, lf_d;
  logic [7:0]             rbuf_q, rbuf_d;
  logic [7:0]             dout_q, dout_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   sclr_q, sclr_d;
  logic [NREG-1:0][7:0]   regs_q, regs_d;

  logic                   wr_go, rd_go;
  logic [13:0]            setup_w;

  // Write beats read on collision; nothing is accepted while a prefetch runs.
  assign cpu_busy = (state_q != IDLE);
  assign wr_go    = cpu_wr & ~cpu_busy;
  assign rd_go    = cpu_rd & ~cpu_wr & ~cpu_busy;
  assign setup_w  = {cpu_din[5:0], latch_q};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    waddr_d = waddr_q;
    latch_d = latch_q;
    lf_d    = lf_q;
    rbuf_d  = rbuf_q;
    dout_d  = dout_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    sclr_d  = 1'b0;
    regs_d  = regs_q;

    case (state_q)
      IDLE: begin
        if (wr_go) begin
          if (cpu_mode) begin
            if (!lf_q) begin
              latch_d = cpu_din;
              lf_d    = 1'b1;
            end else begin
              lf_d = 1'b0;
              if (cpu_din[7]) begin
                for (int i = 0; i < NREG; i++)
                  if (cpu_din[2:0] == 3'(i)) regs_d[i] = latch_q;
              end else begin
                addr_d = ADDR_W'(setup_w);
                if (!cpu_din[6]) state_d = RD_ISSUE;
              end
            end
          end else begin
            // Data write: the VRAM strobe goes out next cycle at the pre-increment address.
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = cpu_din;
            rbuf_d  = cpu_din;
            addr_d  = addr_q + ADDR_W'(1);
            lf_d    = 1'b0;
          end
        end else if (rd_go) begin
          lf_d = 1'b0;
          if (cpu_mode) begin
            dout_d = status_in;
            sclr_d = 1'b1;
          end else begin
            dout_d  = rbuf_q;
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        rbuf_d  = vram_rdata;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pxclk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      waddr_q <= '0;
      latch_q <= '0;
      lf_q    <= 1'b0;
      rbuf_q  <= '0;
      dout_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sclr_q  <= 1'b0;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      waddr_q <= waddr_d;
      latch_q <= latch_d;
      lf_q    <= lf_d;
      rbuf_q  <= rbuf_d;
      dout_q  <= dout_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sclr_q  <= sclr_d;
      regs_q  <= regs_d;
    end
  end

  assign cpu_dout   = dout_q;
  assign status_clr = sclr_q;
  assign vram_we    = we_q;
  assign vram_wdata = wdata_q;
  assign vram_re    = (state_q == RD_ISSUE);
  assign vram_addr  = (state_q == RD_ISSUE) ? addr_q : waddr_q;
  assign regs       = regs_q;

endmodule
